// File: rtl/max6675_temp_sensor.sv
// SPI master that periodically reads the 16-bit conversion word from a MAX6675.
// Optional MAX6675_FAST_START_EN: the first WAIT after reset lasts one clock.
`timescale 1ns/1ps
module max6675_temp_sensor #(
    parameter int unsigned SCK_HALF_CYCLES  = 13,
    parameter int unsigned CONV_WAIT_CYCLES = 22_000_000,
    parameter int unsigned FRAME_BITS       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic [FRAME_BITS-1:0] o_data,
    output logic                  o_CS,
    output logic                  o_SPI_CLk,
    input  logic                  i_SPI_MISO
);

    localparam int unsigned WAIT_W = $clog2(CONV_WAIT_CYCLES + 1);
    localparam int unsigned HALF_W = $clog2(SCK_HALF_CYCLES + 1);
    localparam int unsigned EDGE_W = $clog2(2 * FRAME_BITS + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CONV_WAIT_CYCLES - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_HALF_CYCLES - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                state, next_state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [HALF_W-1:0]     half_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [1:0]            miso_sync;
    logic                  wait_done, half_done, last_edge;

    assign half_done = (half_cnt == HALF_LAST);
    assign last_edge = (edge_cnt == EDGE_LAST);

`ifdef MAX6675_FAST_START_EN
    logic first_wait;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            first_wait <= 1'b1;
        else if (state == ST_WAIT)
            first_wait <= 1'b0;
    end

    assign wait_done = first_wait || (wait_cnt == WAIT_LAST);
`else
    assign wait_done = (wait_cnt == WAIT_LAST);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            miso_sync <= '0;
        else
            miso_sync <= {miso_sync[0], i_SPI_MISO};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= ST_WAIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_WAIT:     if (wait_done) next_state = ST_CS_SETUP;
            ST_CS_SETUP: if (half_done) next_state = ST_SHIFT;
            ST_SHIFT:    if (half_done && last_edge) next_state = ST_DONE;
            ST_DONE:     next_state = ST_WAIT;
            default:     next_state = ST_WAIT;
        endcase
    end

    // The CS_SETUP->SHIFT transition doubles as the first SCK rising edge,
    // so every low->high toggle (and only those) captures a MISO bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_CS      <= 1'b1;
            o_SPI_CLk <= 1'b0;
            o_data    <= '0;
            shreg     <= '0;
            wait_cnt  <= '0;
            half_cnt  <= '0;
            edge_cnt  <= '0;
        end else begin
            o_CS     <= !((next_state == ST_CS_SETUP) || (next_state == ST_SHIFT));
            wait_cnt <= (state == ST_WAIT && !wait_done) ? wait_cnt + WAIT_W'(1) : '0;

            if (state == ST_CS_SETUP || state == ST_SHIFT)
                half_cnt <= half_done ? '0 : half_cnt + HALF_W'(1);
            else
                half_cnt <= '0;

            case (state)
                ST_CS_SETUP: begin
                    if (half_done) begin
                        o_SPI_CLk <= 1'b1;
                        shreg     <= {shreg[FRAME_BITS-2:0], miso_sync[1]};
                    end
                end
                ST_SHIFT: begin
                    if (half_done) begin
                        if (last_edge) begin
                            edge_cnt  <= '0;
                            o_SPI_CLk <= 1'b0;
                        end else begin
                            edge_cnt  <= edge_cnt + EDGE_W'(1);
                            o_SPI_CLk <= !o_SPI_CLk;
                            if (!o_SPI_CLk)
                                shreg <= {shreg[FRAME_BITS-2:0], miso_sync[1]};
                        end
                    end
                end
                ST_DONE: begin
                    o_data    <= shreg;
                    edge_cnt  <= '0;
                    o_SPI_CLk <= 1'b0;
                end
                default: o_SPI_CLk <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_max6675_temp_sensor.sv
// Self-checking bench for max6675_temp_sensor: MAX6675 bus model, framing and reset checks.
// Build with MAX6675_FAST_START_EN defined to exercise the fast first frame.
`timescale 1ns/1ps
module tb_max6675_temp_sensor;

`ifdef MAX6675_FAST_START_EN
    localparam int CONV       = 1000;
    localparam int FIRST_WAIT = 1;
`else
    localparam int CONV       = 100;
    localparam int FIRST_WAIT = CONV;
`endif
    localparam int HALF   = 13;
    localparam int BITS   = 16;
    localparam int CS_LOW = HALF * (1 + 2 * BITS);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miso = 1'b0;
    logic [15:0] data;
    logic        cs, sck;

    int vectors = 0;
    int miscompares = 0;
    bit toggle_en = 1'b0;
    int tcnt = 0;

    always #5 clk = ~clk;

    // Free-running MISO toggler: one level change every 260 ns, unrelated to frame timing.
    always @(negedge clk) begin
        if (toggle_en) begin
            if (tcnt >= 2 * HALF - 1) begin
                tcnt = 0;
                miso = ~miso;
            end else begin
                tcnt++;
            end
        end
    end

    max6675_temp_sensor #(
        .SCK_HALF_CYCLES (HALF),
        .CONV_WAIT_CYCLES(CONV),
        .FRAME_BITS      (BITS)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .o_data    (data),
        .o_CS      (cs),
        .o_SPI_CLk (sck),
        .i_SPI_MISO(miso)
    );

    // Called at a negedge. Waits for CS low, acts as the MAX6675 (MSB on CS fall, next
    // bit after each SCK fall) when drive=1, and measures the frame. Returns at the
    // first negedge with CS high again.
    task automatic do_frame(input logic [15:0] word, input bit drive, output int low_cyc,
                            output int rises, output int bad_gap, output int data_chg,
                            output bit timeout);
        int idx, wait_n, cyc, last_rise;
        logic prev_sck;
        logic [15:0] d0;
        low_cyc = 0; rises = 0; bad_gap = 0; data_chg = 0; timeout = 1'b0; wait_n = 0;
        while (cs !== 1'b0 && wait_n < CONV + 2000) begin
            @(negedge clk);
            wait_n++;
        end
        if (cs !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        d0 = data;
        idx = BITS - 2;
        if (drive) miso = word[BITS-1];
        prev_sck = sck;
        cyc = 0;
        last_rise = -1;
        while (cs === 1'b0 && low_cyc < 2000) begin
            low_cyc++;
            if (sck === 1'b1 && prev_sck === 1'b0) begin
                rises++;
                if (last_rise >= 0 && cyc - last_rise != 2 * HALF) bad_gap++;
                last_rise = cyc;
            end
            if (sck === 1'b0 && prev_sck === 1'b1 && drive) begin
                miso = (idx >= 0) ? word[idx] : 1'b0;
                idx--;
            end
            if (data !== d0) data_chg++;
            prev_sck = sck;
            cyc++;
            @(negedge clk);
        end
        if (data !== d0) data_chg++;
        if (cs === 1'b0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        miso = 1'b1;
        repeat (50) @(negedge clk);
        vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs: got %b expected 1", cs); end
        vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL reset_sck: got %b expected 0", sck); end
        vectors++; if (data !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h expected 0000", data); end
        repeat (50) @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (cs !== 1'b0 && n < CONV + 50);
        vectors++; if (n != FIRST_WAIT) begin miscompares++; $display("FAIL first_cs_fall: got %0d clocks expected %0d", n, FIRST_WAIT); end
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        int low, rises, gap, chg;
        bit to;
        do_frame(16'h0000, 1'b0, low, rises, gap, chg, to);
        vectors++; if (to) begin miscompares++; $display("FAIL ones_timeout: got timeout expected frame"); end
        vectors++; if (low != CS_LOW) begin miscompares++; $display("FAIL ones_cs_low: got %0d expected %0d", low, CS_LOW); end
        vectors++; if (rises != BITS) begin miscompares++; $display("FAIL ones_sck_rises: got %0d expected %0d", rises, BITS); end
        vectors++; if (gap != 0) begin miscompares++; $display("FAIL ones_sck_period: got %0d bad gaps expected 0", gap); end
        vectors++; if (chg != 0) begin miscompares++; $display("FAIL ones_early_data: got %0d changes expected 0", chg); end
        @(negedge clk);
        vectors++; if (data !== 16'hFFFF) begin miscompares++; $display("FAIL ones_data: got %h expected ffff", data); end
    endtask

    task automatic test_known_word();
        int low, rises, gap, chg, hi, held;
        bit to;
        miso = 1'b0;
        do_frame(16'h0C84, 1'b1, low, rises, gap, chg, to);
        vectors++; if (to || chg != 0) begin miscompares++; $display("FAIL known_frame: got timeout=%0d changes=%0d expected 0/0", to, chg); end
        @(negedge clk);
        vectors++; if (data !== 16'h0C84) begin miscompares++; $display("FAIL known_data: got %h expected 0c84", data); end
        // CS stays high for DONE plus the full WAIT period.
        hi = 2;
        held = 0;
        while (hi < CONV + 100) begin
            @(negedge clk);
            if (cs !== 1'b1) break;
            hi++;
            if (data !== 16'h0C84) held++;
        end
        vectors++; if (hi != CONV + 1) begin miscompares++; $display("FAIL frame_gap: got %0d clocks expected %0d", hi, CONV + 1); end
        vectors++; if (held != 0) begin miscompares++; $display("FAIL known_hold: got %0d changes expected 0", held); end
    endtask

    task automatic test_random_words();
        int low, rises, gap, chg;
        bit to;
        logic [15:0] w;
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            do_frame(w, 1'b1, low, rises, gap, chg, to);
            vectors++; if (to) begin miscompares++; $display("FAIL rand_timeout[%0d]: got timeout expected frame", i); end
            vectors++; if (low != CS_LOW || rises != BITS) begin miscompares++; $display("FAIL rand_framing[%0d]: got low=%0d rises=%0d expected %0d/%0d", i, low, rises, CS_LOW, BITS); end
            vectors++; if (chg != 0) begin miscompares++; $display("FAIL rand_early_data[%0d]: got %0d changes expected 0", i, chg); end
            @(negedge clk);
            vectors++; if (data !== w) begin miscompares++; $display("FAIL rand_data[%0d]: got %h expected %h", i, data, w); end
        end
    endtask

    task automatic test_async_toggle();
        int low, rises, gap, chg;
        bit to;
        tcnt = int'($urandom_range(0, 2 * HALF - 1));
        toggle_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_frame(16'h0000, 1'b0, low, rises, gap, chg, to);
            vectors++; if (to || chg != 0) begin miscompares++; $display("FAIL toggle_frame[%0d]: got timeout=%0d changes=%0d expected 0/0", i, to, chg); end
            @(negedge clk);
            vectors++; if (data !== 16'hAAAA && data !== 16'h5555) begin miscompares++; $display("FAIL toggle_data[%0d]: got %h expected aaaa or 5555", i, data); end
        end
        toggle_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int n, low, rises, gap, chg;
        bit to;
        logic [15:0] w;
        n = 0;
        while (cs !== 1'b0 && n < CONV + 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (HALF + BITS * HALF) @(negedge clk);
        vectors++; if (cs !== 1'b0) begin miscompares++; $display("FAIL mid_precond_cs: got %b expected 0", cs); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL mid_reset_cs: got %b expected 1", cs); end
        vectors++; if (sck !== 1'b0) begin miscompares++; $display("FAIL mid_reset_sck: got %b expected 0", sck); end
        vectors++; if (data !== 16'h0000) begin miscompares++; $display("FAIL mid_reset_data: got %h expected 0000", data); end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (cs !== 1'b0 && n < CONV + 50);
        vectors++; if (n != FIRST_WAIT) begin miscompares++; $display("FAIL mid_restart: got %0d clocks expected %0d", n, FIRST_WAIT); end
        @(negedge clk);
        w = 16'($urandom);
        do_frame(w, 1'b1, low, rises, gap, chg, to);
        vectors++; if (to || low != CS_LOW) begin miscompares++; $display("FAIL mid_frame: got timeout=%0d low=%0d expected 0/%0d", to, low, CS_LOW); end
        @(negedge clk);
        vectors++; if (data !== w) begin miscompares++; $display("FAIL mid_data: got %h expected %h", data, w); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_known_word();
        test_random_words();
        test_async_toggle();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish within 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
